// File: rtl/sar_stim_pkg.sv
// Shared types and helpers for the SAR stimulus generator.
// next_target honours SAR_STIM_LFSR_EN (LFSR when defined, counter otherwise).
package sar_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_START,
    ST_CONV,
    ST_CHECK,
    ST_DONE
  } stim_state_t;

  // Galois right-shift feedback masks giving maximal-length sequences, by width.
  function automatic logic [15:0] lfsr_taps(input int unsigned n_bits);
    logic [15:0] taps;
    case (n_bits)
      2:       taps = 16'h0003;
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0E08;
      13:      taps = 16'h1C80;
      14:      taps = 16'h3802;
      15:      taps = 16'h6000;
      16:      taps = 16'hB400;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  function automatic logic [15:0] next_target(input logic [15:0]   cur,
                                              input int unsigned   n_bits,
                                              input logic [15:0]   step);
    logic [15:0] mask;
    logic [15:0] nxt;
    mask = 16'((32'd1 << n_bits) - 32'd1);
`ifdef SAR_STIM_LFSR_EN
    nxt = cur >> 1;
    if (cur[0]) nxt = nxt ^ lfsr_taps(n_bits);
`else
    nxt = cur + step;
`endif
    return nxt & mask;
  endfunction

endpackage

// File: rtl/sar_stim_target_gen.sv
// Target code register for the SAR stimulus generator; advances once per checked conversion.
// SAR_STIM_LFSR_EN selects the Galois LFSR sequence, otherwise a fixed-step counter.
module sar_stim_target_gen
  import sar_stim_pkg::*;
#(
  parameter int unsigned N_BITS   = 8,
  parameter int unsigned TGT_SEED = 1,
  parameter int unsigned TGT_STEP = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  output logic [N_BITS-1:0] o_target
);

  localparam logic [15:0] SEED16 = 16'(TGT_SEED);
  localparam logic [15:0] STEP16 = 16'(TGT_STEP);
`ifdef SAR_STIM_LFSR_EN
  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
  localparam logic [N_BITS-1:0] RST_TGT =
    (SEED16[N_BITS-1:0] == '0) ? {{(N_BITS-1){1'b0}}, 1'b1} : SEED16[N_BITS-1:0];
`else
  localparam logic [N_BITS-1:0] RST_TGT = SEED16[N_BITS-1:0];
`endif

  logic [N_BITS-1:0] r_target;
  logic [15:0]       w_next16;

  assign w_next16 = next_target(16'(r_target), N_BITS, STEP16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= RST_TGT;
    end else if (i_advance) begin
      r_target <= w_next16[N_BITS-1:0];
    end
  end

  assign o_target = r_target;

endmodule

// File: rtl/sar_stimulus_gen.sv
// Stimulus/comparator model for N-bit SAR ADC control logic: issues starts, answers trials, checks results.
// Target sequence mode is chosen by SAR_STIM_LFSR_EN (see sar_stim_target_gen).
module sar_stimulus_gen
  import sar_stim_pkg::*;
#(
  parameter int unsigned N_BITS    = 8,
  parameter int unsigned N_CONV    = 16,
  parameter int unsigned START_GAP = 4,
  parameter int unsigned COMP_LAT  = 1,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TGT_SEED  = 1,
  parameter int unsigned TGT_STEP  = 37
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_BITS-1:0] sar_code,
  input  logic              sar_eoc,
  output logic              start,
  output logic              comp,
  output logic [N_BITS-1:0] target,
  output logic [15:0]       conv_cnt,
  output logic              err,
  output logic              timeout,
  output logic              done
);

  localparam int unsigned      GAP_W    = (START_GAP > 1) ? $clog2(START_GAP) : 1;
  localparam int unsigned      TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(START_GAP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [15:0]      CONV_END = 16'(N_CONV);

  stim_state_t       r_state;
  stim_state_t       w_state_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [COMP_LAT-1:0] r_comp_pipe;
  logic [N_BITS-1:0] r_result;
  logic              r_conv_to;
  logic              r_err;
  logic              r_timeout;
  logic [15:0]       r_conv_cnt;
  logic [15:0]       w_conv_cnt_inc;
  logic              w_gap_done;
  logic              w_to_hit;
  logic              w_run_end;
  logic              w_advance;

  always_comb begin
    w_gap_done     = (r_gap_cnt == GAP_LAST);
    w_to_hit       = (r_to_cnt == TO_LAST);
    w_conv_cnt_inc = (r_conv_cnt == 16'hFFFF) ? r_conv_cnt : r_conv_cnt + 16'd1;
    w_run_end      = (N_CONV != 0) && (w_conv_cnt_inc == CONV_END);
    w_advance      = en && (r_state == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_GAP;
        ST_GAP:   if (w_gap_done) w_state_nxt = ST_START;
        ST_START: w_state_nxt = ST_CONV;
        ST_CONV:  if (sar_eoc || w_to_hit) w_state_nxt = ST_CHECK;
        ST_CHECK: w_state_nxt = w_run_end ? ST_DONE : ST_GAP;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt  <= '0;
      r_to_cnt   <= '0;
      r_result   <= '0;
      r_conv_to  <= 1'b0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
      r_conv_cnt <= '0;
    end else begin
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
      // Counts CONV cycles; an eoc is accepted on any of the first TIMEOUT cycles after start.
      r_to_cnt  <= (r_state == ST_CONV) ? r_to_cnt + 1'b1 : '0;
      if (en) begin
        case (r_state)
          ST_IDLE: begin
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_conv_cnt <= '0;
          end
          ST_CONV: begin
            if (sar_eoc) begin
              r_result  <= sar_code;
              r_conv_to <= 1'b0;
            end else if (w_to_hit) begin
              r_conv_to <= 1'b1;
              r_timeout <= 1'b1;
              r_err     <= 1'b1;
            end
          end
          ST_CHECK: begin
            if (!r_conv_to && (r_result != target)) r_err <= 1'b1;
            r_conv_cnt <= w_conv_cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the comparator delay line is reset and cleared outside CONV so stale decisions never leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_comp_pipe <= '0;
    end else if (r_state == ST_CONV) begin
      r_comp_pipe[0] <= (target >= sar_code);
      for (int i = 1; i < COMP_LAT; i++) r_comp_pipe[i] <= r_comp_pipe[i-1];
    end else begin
      r_comp_pipe <= '0;
    end
  end

  sar_stim_target_gen #(
    .N_BITS   (N_BITS),
    .TGT_SEED (TGT_SEED),
    .TGT_STEP (TGT_STEP)
  ) u_target_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_advance (w_advance),
    .o_target  (target)
  );

  assign start    = (r_state == ST_START);
  assign done     = (r_state == ST_DONE);
  assign comp     = (r_state == ST_CONV) && r_comp_pipe[COMP_LAT-1];
  assign conv_cnt = r_conv_cnt;
  assign err      = r_err;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_sar_stimulus_gen.sv
// Closed-loop bench: behavioural SAR converter driving the stimulus generator, randomized timing,
// comparator latency, bad results, timeout, abort and async reset.
module tb_sar_stimulus_gen;

  localparam int NB    = 8;
  localparam int NCONV = 16;
  localparam int GAP   = 4;
  localparam int TO    = 64;
  localparam int STEP  = 37;
  localparam int M_OK  = 0;
  localparam int M_BAD = 1;
  localparam int M_TO  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          en_a, eoc_a, start_a, comp_a, err_a, timeout_a, done_a;
  logic [NB-1:0] sar_code_a, target_a;
  logic [15:0]   conv_cnt_a;
  logic          en_b, eoc_b, start_b, comp_b, err_b, timeout_b, done_b;
  logic [NB-1:0] sar_code_b, target_b;
  logic [15:0]   conv_cnt_b;

  always #5 clk = ~clk;

  sar_stimulus_gen #(
    .N_BITS(NB), .N_CONV(NCONV), .START_GAP(GAP), .COMP_LAT(1),
    .TIMEOUT(TO), .TGT_SEED(1), .TGT_STEP(STEP)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .sar_code(sar_code_a), .sar_eoc(eoc_a),
    .start(start_a), .comp(comp_a), .target(target_a), .conv_cnt(conv_cnt_a),
    .err(err_a), .timeout(timeout_a), .done(done_a)
  );

  sar_stimulus_gen #(
    .N_BITS(NB), .N_CONV(1), .START_GAP(GAP), .COMP_LAT(4),
    .TIMEOUT(TO), .TGT_SEED(128), .TGT_STEP(STEP)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sar_code(sar_code_b), .sar_eoc(eoc_b),
    .start(start_b), .comp(comp_b), .target(target_b), .conv_cnt(conv_cnt_b),
    .err(err_b), .timeout(timeout_b), .done(done_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int starts_a = 0;

  logic [NB-1:0] tgt_a, tgt_b;
  logic          exp_err, exp_to;
  int            exp_cnt;

  always @(negedge clk) if (start_a === 1'b1) starts_a++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next target from the sequence rules: fixed step mod 2^NB, or the maximal 8-bit Galois LFSR.
  function automatic logic [NB-1:0] adv(input logic [NB-1:0] t);
`ifdef SAR_STIM_LFSR_EN
    return t[0] ? ((t >> 1) ^ 8'hB8) : (t >> 1);
`else
    return 8'((int'(t) + STEP) % 256);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_a(output int n);
    n = 0;
    while (start_a !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("start_seen", start_a, 1'b1);
  endtask

  // Entered in the START cycle; returns in the cycle after CHECK.
  task automatic convert_a(input int mode, input bit eoc_last);
    logic [NB-1:0] res, trial, out;
    int e;
    check("tgt_at_start", target_a, tgt_a);
    tick();
    e = 1;
    if (mode == M_TO) begin
      sar_code_a = 8'($urandom);
      repeat (TO - 1) tick();
      check("timeout_pre", timeout_a, 1'b0);
      tick();
      check("timeout_set", timeout_a, 1'b1);
      check("timeout_err", err_a, 1'b1);
      exp_err = 1'b1;
      exp_to  = 1'b1;
    end else begin
      res = '0;
      for (int b = NB - 1; b >= 0; b--) begin
        trial = res | (8'd1 << b);
        sar_code_a = trial;
        tick();
        e++;
        check("comp_a", comp_a, (tgt_a >= trial));
        if (comp_a) res = trial;
      end
      check("sar_result", res, tgt_a);
      if (eoc_last) repeat (TO - e) tick();
      else          repeat ($urandom_range(0, 3)) tick();
      out = (mode == M_BAD) ? 8'h00 : res;
      sar_code_a = out;
      eoc_a = 1'b1;
      tick();
      eoc_a = 1'b0;
      check("comp_off_check", comp_a, 1'b0);
      if (out != tgt_a) exp_err = 1'b1;
    end
    tick();
    exp_cnt++;
    tgt_a = adv(tgt_a);
    check("conv_cnt", conv_cnt_a, exp_cnt);
    check("err", err_a, exp_err);
    check("timeout", timeout_a, exp_to);
    check("target_next", target_a, tgt_a);
    check("done", done_a, (exp_cnt == NCONV));
  endtask

  task automatic abort_a();
    int s;
    tick();
    sar_code_a = 8'h80;
    repeat ($urandom_range(1, 6)) tick();
    en_a = 1'b0;
    tick();
    check("abort_comp", comp_a, 1'b0);
    check("abort_start", start_a, 1'b0);
    check("abort_cnt", conv_cnt_a, exp_cnt);
    check("abort_err", err_a, exp_err);
    s = starts_a;
    repeat (20) tick();
    check("abort_no_start", starts_a - s, 0);
    check("abort_done", done_a, 1'b0);
  endtask

  task automatic reset_a();
    tick();
    sar_code_a = 8'h80;
    repeat (3) tick();
    check("pre_rst_err", err_a, exp_err);
    #2 rst_n = 1'b0;
    #1;
    check("rst_start", start_a, 1'b0);
    check("rst_comp", comp_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_timeout", timeout_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_cnt", conv_cnt_a, 0);
    check("rst_target", target_a, 1);
    en_a = 1'b0;
    tgt_a = 8'd1;
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_target", target_a, tgt_a);
  endtask

  task automatic run_a(input int bad_k, input int last_k, input int to_k,
                       input int abort_k, input int rst_k);
    int n, s0, mode;
    s0 = starts_a;
    repeat ($urandom_range(1, 4)) tick();
    en_a = 1'b1;
    exp_err = 1'b0;
    exp_to  = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < NCONV; k++) begin
      wait_start_a(n);
      if (k == 0) begin
        check("gap_first", n, GAP + 1);
        check("cnt_clr", conv_cnt_a, 0);
        check("err_clr", err_a, 1'b0);
        check("to_clr", timeout_a, 1'b0);
      end else begin
        check("gap", n, GAP);
      end
      if (k == abort_k) begin
        abort_a();
        return;
      end
      if (k == rst_k) begin
        reset_a();
        return;
      end
      mode = (k == to_k) ? M_TO : ((k == bad_k) ? M_BAD : M_OK);
      convert_a(mode, (k == last_k));
    end
    check("done_final", done_a, 1'b1);
    check("starts", starts_a - s0, NCONV);
    repeat (5) tick();
    check("done_hold", done_a, 1'b1);
    check("no_extra_start", starts_a - s0, NCONV);
    en_a = 1'b0;
    tick();
    check("done_clr", done_a, 1'b0);
    check("cnt_hold", conv_cnt_a, NCONV);
  endtask

  // COMP_LAT=4 instance: random trial codes each cycle, comp checked against a 4-deep history.
  task automatic run_b();
    logic [NB-1:0] codes [24];
    int n;
    codes[0] = 8'h80;
    codes[1] = 8'h81;
    codes[2] = 8'h7F;
    for (int i = 3; i < 24; i++)
      codes[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
    en_b = 1'b1;
    n = 0;
    while (start_b !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("b_start", start_b, 1'b1);
    check("b_target", target_b, tgt_b);
    tick();
    for (int k = 0; k <= 24; k++) begin
      check("b_comp", comp_b, (k >= 4) ? (tgt_b >= codes[k-4]) : 1'b0);
      if (k < 24) begin
        sar_code_b = codes[k];
        tick();
      end
    end
    sar_code_b = tgt_b;
    eoc_b = 1'b1;
    tick();
    eoc_b = 1'b0;
    check("b_comp_check", comp_b, 1'b0);
    tick();
    tgt_b = adv(tgt_b);
    check("b_done", done_b, 1'b1);
    check("b_comp_done", comp_b, 1'b0);
    check("b_err", err_b, 1'b0);
    check("b_timeout", timeout_b, 1'b0);
    check("b_cnt", conv_cnt_b, 1);
    check("b_target_next", target_b, tgt_b);
    en_b = 1'b0;
    tick();
    check("b_done_clr", done_b, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, elapsed %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    en_a = 1'b0; eoc_a = 1'b0; sar_code_a = '0;
    en_b = 1'b0; eoc_b = 1'b0; sar_code_b = '0;
    tgt_a = 8'd1;
    tgt_b = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    check("reset_start", start_a, 1'b0);
    check("reset_comp", comp_a, 1'b0);
    check("reset_err", err_a, 1'b0);
    check("reset_timeout", timeout_a, 1'b0);
    check("reset_done", done_a, 1'b0);
    check("reset_cnt", conv_cnt_a, 0);
    check("reset_target", target_a, tgt_a);
    rst_n = 1'b1;
    tick();

    run_b();
    run_a(-1, -1, -1, -1, -1);
    run_a(3, 5, -1, -1, -1);
    run_a(-1, -1, 0, 2, -1);
    run_a(0, -1, -1, -1, 1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
